// File: rtl/ipsxe_floating_point_find_one_arbiter_v1_0_if.sv
// ipsxe_floating_point_find_one_arbiter_v1_0_if: requester/finder bus of the shared leading-one finder arbiter.
interface ipsxe_floating_point_find_one_arbiter_v1_0_if #(
   parameter int NUM_REQ = 4
);
   logic                   i_clken;
   logic [NUM_REQ-1:0]     i_req;
   logic [32*NUM_REQ-1:0]  i_din;
   logic [NUM_REQ-1:0]     o_gnt;
   logic [31:0]            o_fo_din;
   logic [4:0]             i_fo_index;
   logic [NUM_REQ-1:0]     o_rsp_valid;
   logic [4:0]             o_rsp_index;
   logic                   o_rsp_zero;
   logic                   o_busy;
   modport slave (
      input  i_clken, i_req, i_din, i_fo_index,
      output o_gnt, o_fo_din, o_rsp_valid, o_rsp_index, o_rsp_zero, o_busy
   );
   modport master (
      output i_clken, i_req, i_din, i_fo_index,
      input  o_gnt, o_fo_din, o_rsp_valid, o_rsp_index, o_rsp_zero, o_busy
   );
endinterface

// File: rtl/ipsxe_floating_point_find_one_arbiter_v1_0.sv
// ipsxe_floating_point_find_one_arbiter_v1_0: shares one pipelined leading-one finder among NUM_REQ lanes.
// Define IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN for lowest-lane-wins priority instead of round robin.
module ipsxe_floating_point_find_one_arbiter_v1_0 #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 3
) (
   input logic i_clk,
   input logic i_rst_n,
   ipsxe_floating_point_find_one_arbiter_v1_0_if.slave bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(LATENCY + 2);
   logic [PW-1:0]      w_win, w_idx;
   logic               w_g;
   logic [31:0]        w_word;
   logic [31:0]        r_fo_din;
   logic [LATENCY:0]   r_vld, r_zero;
   logic [PW-1:0]      r_id [0:LATENCY];
   logic [CW-1:0]      r_cnt;
`ifndef IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN
   logic [PW-1:0]      r_ptr;
`endif
   // Scan from the highest offset down so the lowest offset from the search start wins.
   always_comb begin
      w_win = '0;
      w_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN
         w_idx = PW'(k);
`else
         w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
`endif
         if (bus.i_req[w_idx]) w_win = w_idx;
      end
   end
   assign w_g    = bus.i_clken & (|bus.i_req);
   assign w_word = bus.i_din[32*w_win +: 32];
   assign bus.o_gnt       = w_g ? NUM_REQ'(1) << w_win : '0;
   assign bus.o_fo_din    = r_fo_din;
   assign bus.o_rsp_valid = r_vld[LATENCY] ? NUM_REQ'(1) << r_id[LATENCY] : '0;
   assign bus.o_rsp_index = (r_vld[LATENCY] & ~r_zero[LATENCY]) ? bus.i_fo_index : '0;
   assign bus.o_rsp_zero  = r_vld[LATENCY] & r_zero[LATENCY];
   assign bus.o_busy      = r_cnt != '0;
   // Tag line shifts only on enabled edges so it stays aligned with the finder pipeline.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_fo_din <= '0;
         r_vld    <= '0;
         r_zero   <= '0;
         r_cnt    <= '0;
         for (int s = 0; s <= LATENCY; s++) r_id[s] <= '0;
`ifndef IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN
         r_ptr    <= '0;
`endif
      end else if (bus.i_clken) begin
         r_fo_din  <= w_g ? w_word : '0;
         r_vld[0]  <= w_g;
         r_zero[0] <= w_g & (w_word == '0);
         r_id[0]   <= w_win;
         for (int s = LATENCY; s > 0; s--) begin
            r_vld[s]  <= r_vld[s-1];
            r_zero[s] <= r_zero[s-1];
            r_id[s]   <= r_id[s-1];
         end
         r_cnt <= r_cnt + CW'(w_g) - CW'(r_vld[LATENCY]);
`ifndef IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN
         if (w_g) r_ptr <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
`endif
      end
endmodule

// File: tb/tb_ipsxe_floating_point_find_one_arbiter_v1_0.sv
// tb_ipsxe_floating_point_find_one_arbiter_v1_0: directed vectors for the shared finder arbiter with a 3-stage finder model.
module tb_ipsxe_floating_point_find_one_arbiter_v1_0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [4:0] p0, p1, p2;
   ipsxe_floating_point_find_one_arbiter_v1_0_if #(.NUM_REQ(4)) bus ();
   ipsxe_floating_point_find_one_arbiter_v1_0 #(.NUM_REQ(4), .LATENCY(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [4:0] lead1(logic [31:0] w);
      lead1 = '0;
      for (int i = 0; i < 32; i++) if (w[i]) lead1 = 5'(i);
   endfunction
   // Reference finder: index of the leading one, three enabled edges after its input.
   always @(posedge clk)
      if (bus.i_clken) begin
         p0 <= lead1(bus.o_fo_din);
         p1 <= p0;
         p2 <= p1;
      end
   assign bus.i_fo_index = p2;
   typedef struct {
      logic         rst;
      logic [3:0]   req;
      logic [127:0] din;
      logic [3:0]   gnt;
      logic [3:0]   rv;
      logic [4:0]   ri;
      logic         rz;
      logic         busy;
   } vec_t;
   vec_t tbl[$];
   task automatic add(logic rst, logic [3:0] req, logic [127:0] din, logic [3:0] gnt,
                      logic [3:0] rv, logic [4:0] ri, logic rz, logic busy);
      vec_t v;
      v.rst = rst; v.req = req; v.din = din; v.gnt = gnt;
      v.rv = rv; v.ri = ri; v.rz = rz; v.busy = busy;
      tbl.push_back(v);
   endtask
   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", n, a, e);
      end
   endtask
   task automatic chk_out(string n, logic [3:0] gnt, logic [3:0] rv, logic [4:0] ri, logic rz, logic busy);
      chk({n, " gnt"}, 32'(bus.o_gnt), 32'(gnt));
      chk({n, " rsp_valid"}, 32'(bus.o_rsp_valid), 32'(rv));
      chk({n, " rsp_index"}, 32'(bus.o_rsp_index), 32'(ri));
      chk({n, " rsp_zero"}, 32'(bus.o_rsp_zero), 32'(rz));
      chk({n, " busy"}, 32'(bus.o_busy), 32'(busy));
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.i_req = '0;
      bus.i_clken = 1'b1;
      #1;
      chk_out("reset", 4'b0, 4'b0, 5'd0, 1'b0, 1'b0);
      chk("reset fo_din", bus.o_fo_din, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   localparam logic [127:0] W1 = {32'h0, 32'h0, 32'h0000_8000, 32'h0};
   localparam logic [127:0] W2 = {32'h4000_0000, 32'h0002_0000, 32'h0000_0040, 32'h0000_0003};
   localparam logic [127:0] W3 = {32'h0, 32'h0, 32'h0, 32'h1};
   localparam logic [127:0] WR = {32'h8000_0000, 32'h0, 32'h0, 32'h1};
   initial begin
      logic [4:0] t2i [4];
      t2i = '{5'd1, 5'd6, 5'd17, 5'd30};
      bus.i_clken = 1'b1;
      bus.i_req = '0;
      bus.i_din = '0;
      // single lane1 request
      add(1, 4'b0010, W1, 4'b0010, 4'b0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 4'b0, W1, 4'b0, 4'b0, 0, 0, 1);
      add(0, 4'b0, W1, 4'b0, 4'b0010, 15, 0, 1);
      add(0, 4'b0, W1, 4'b0, 4'b0, 0, 0, 0);
`ifndef IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN
      // all lanes request continuously: rotating grants, in-order responses
      for (int i = 0; i < 12; i++)
         add(i == 0, i < 8 ? 4'b1111 : 4'b0, W2, i < 8 ? 4'(1) << (i % 4) : 4'b0,
             i >= 4 ? 4'(1) << (i % 4) : 4'b0, i >= 4 ? t2i[i % 4] : 5'd0, 0, i != 0);
      add(0, 4'b0, W2, 4'b0, 4'b0, 0, 0, 0);
`endif
      // zero word versus 0x1
      add(0, 4'b0100, W3, 4'b0100, 4'b0, 0, 0, 0);
      add(0, 4'b0001, W3, 4'b0001, 4'b0, 0, 0, 1);
      for (int i = 0; i < 2; i++) add(0, 4'b0, W3, 4'b0, 4'b0, 0, 0, 1);
      add(0, 4'b0, W3, 4'b0, 4'b0100, 0, 1, 1);
      add(0, 4'b0, W3, 4'b0, 4'b0001, 0, 0, 1);
      add(0, 4'b0, W3, 4'b0, 4'b0, 0, 0, 0);
`ifndef IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN
      // pointer at 1: lane3 before lane0, then wrap to lane0
      add(0, 4'b1001, WR, 4'b1000, 4'b0, 0, 0, 0);
      add(0, 4'b1001, WR, 4'b0001, 4'b0, 0, 0, 1);
      for (int i = 0; i < 2; i++) add(0, 4'b0, WR, 4'b0, 4'b0, 0, 0, 1);
      add(0, 4'b0, WR, 4'b0, 4'b1000, 31, 0, 1);
      add(0, 4'b0, WR, 4'b0, 4'b0001, 0, 0, 1);
      add(0, 4'b0, WR, 4'b0, 4'b0, 0, 0, 0);
`endif
      foreach (tbl[n]) begin
         if (tbl[n].rst) do_reset();
         @(negedge clk);
         bus.i_clken = 1'b1;
         bus.i_req = tbl[n].req;
         bus.i_din = tbl[n].din;
         #1;
         chk_out($sformatf("vec%0d", n), tbl[n].gnt, tbl[n].rv, tbl[n].ri, tbl[n].rz, tbl[n].busy);
      end
      // clock-enable stall mid-flight and with the response showing
      do_reset();
      @(negedge clk);
      bus.i_req = 4'b1000;
      bus.i_din = WR;
      #1;
      chk("stall gnt", 32'(bus.o_gnt), 32'h8);
      @(negedge clk);
      bus.i_req = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.i_clken = 1'b0;
         bus.i_req = 4'b1111;
         #1;
         chk_out($sformatf("stall%0d", i), 4'b0, 4'b0, 0, 0, 1);
      end
      @(negedge clk);
      bus.i_clken = 1'b1;
      bus.i_req = '0;
      #1;
      chk("resume0 rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk("resume1 rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk_out("resume2", 4'b0, 4'b1000, 31, 0, 1);
      bus.i_clken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk_out($sformatf("hold%0d", i), 4'b0, 4'b1000, 31, 0, 1);
      end
      bus.i_clken = 1'b1;
      @(negedge clk);
      #1;
      chk_out("no repeat", 4'b0, 4'b0, 0, 0, 0);
      // async reset with two words in flight
      do_reset();
      @(negedge clk);
      bus.i_din = {32'h0, 32'h0, 32'h20, 32'h10};
      bus.i_req = 4'b0001;
      #1;
      chk("rst-flight gnt0", 32'(bus.o_gnt), 32'h1);
      @(negedge clk);
      bus.i_req = 4'b0010;
      #1;
      chk("rst-flight gnt1", 32'(bus.o_gnt), 32'h2);
      @(negedge clk);
      bus.i_req = '0;
      #1;
      chk("rst-flight busy", 32'(bus.o_busy), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_out("rst-flight now", 4'b0, 4'b0, 0, 0, 0);
      chk("rst-flight fo_din", bus.o_fo_din, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         chk_out($sformatf("post-rst%0d", i), 4'b0, 4'b0, 0, 0, 0);
      end
      // lanes 0 and 2 requesting continuously
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.i_req = 4'b0101;
         bus.i_din = W3;
         #1;
`ifdef IPSXE_FLT_FIND_ONE_ARB_FIXED_PRIO_EN
         chk($sformatf("prio gnt%0d", i), 32'(bus.o_gnt), 32'h1);
`else
         chk($sformatf("prio gnt%0d", i), 32'(bus.o_gnt), (i % 2 == 0) ? 32'h1 : 32'h4);
`endif
      end
      @(negedge clk);
      bus.i_req = '0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
